// File: rtl/iterative_multiplier.sv
// Multi-cycle radix-2^R shift-add multiplier with per-operand signedness,
// early termination, abort and a start/busy/done handshake.
module iterative_multiplier #(
  parameter int N_BIT      = 32,
  parameter int RADIX_LOG2 = 2,
  parameter int RES_BIT    = 2 * N_BIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [N_BIT-1:0]   a,
  input  logic [N_BIT-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  output logic               busy,
  output logic               done,
  output logic [RES_BIT-1:0] out
);

  // Handshake: start is taken on a rising edge only while busy=0; abort wins
  // over start. done stays high until the next accepted start, abort or reset.

  localparam int R     = RADIX_LOG2;
  localparam int STEPS = N_BIT / R;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LAST  = STEPS - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [N_BIT-1:0]   mplier;
  logic [RES_BIT-1:0] mcand;
  logic [RES_BIT-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [RES_BIT-1:0] out_q;

  logic               a_neg;
  logic               b_neg;
  logic [N_BIT-1:0]   a_mag;
  logic [N_BIT-1:0]   b_mag;
  logic [RES_BIT-1:0] pp;
  logic [RES_BIT-1:0] sum;
  logic [N_BIT-1:0]   mplier_shift;
  logic               last;
  logic               accept;
  logic               finish;

  // Operand magnitudes; the most negative value maps onto 2^(N_BIT-1),
  // which still fits the unsigned N_BIT register.
  assign a_neg = a_signed & a[N_BIT-1];
  assign b_neg = b_signed & b[N_BIT-1];
  assign a_mag = a_neg ? (-a) : a;
  assign b_mag = b_neg ? (-b) : b;

  assign pp           = mcand * RES_BIT'(mplier[R-1:0]);
  assign sum          = acc + pp;
  assign mplier_shift = mplier >> R;
  assign last         = (mplier_shift == '0) || (cnt == CNT_W'(LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (!abort && start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (last) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      out_q  <= '0;
    end else if (accept) begin
      mplier <= a_mag;
      mcand  <= RES_BIT'(b_mag);
      acc    <= '0;
      cnt    <= '0;
      neg    <= a_neg ^ b_neg;
    end else if (state == RUN && !abort) begin
      acc    <= sum;
      mplier <= mplier_shift;
      mcand  <= mcand << R;
      cnt    <= cnt + CNT_W'(1);
      if (finish) begin
        out_q <= neg ? (-sum) : sum;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign out  = out_q;

endmodule

// File: doc/iterative_multiplier.md
Name:
iterative_multiplier

Overview:
Multi-cycle radix-2^R shift-add multiplier. It is the parametrised successor of the current single-bit unsigned serial multiplier and retires R multiplier bits per cycle. It adds per-operand signed/unsigned mode (covers MUL/MULH/MULHSU/MULHU), early termination on exhausted multiplier bits, an abort, and a start/busy/done handshake. It sits beside the ALU in the core execute stage.

Parameters:
N_BIT, 32, operand width in bits (>=2).
RADIX_LOG2, 2, multiplier bits retired per cycle (R); must divide N_BIT.
RES_BIT, 2*N_BIT, result width; fixed at 2*N_BIT, do not override.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; accepted only when busy=0.
abort  input  1  kill the current operation.
a  input  N_BIT  multiplier operand (digits consumed from a).
b  input  N_BIT  multiplicand operand.
a_signed  input  1  treat a as two's complement.
b_signed  input  1  treat b as two's complement.
busy  output  1  operation in progress.
done  output  1  result valid; held until next accepted start, abort or reset.
out  output  RES_BIT  product, two's complement if either operand is signed, else unsigned.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, out=0, all internal registers 0. Reset mid-operation discards it with no done pulse.
- States: IDLE, RUN, DONE. busy=1 only in RUN. done=1 only in DONE.
- Accept: edge with start=1 and state in {IDLE, DONE}.
  - Latch mplier=|a| (N_BIT unsigned) and mcand=|b| zero-extended to RES_BIT.
  - |x| is x when the operand is unsigned or non-negative, else -x. For -2^(N_BIT-1) the magnitude is 2^(N_BIT-1), which fits in N_BIT bits unsigned.
  - Set neg = (a_signed&a[MSB]) ^ (b_signed&b[MSB]). acc=0, cnt=0, done->0, state->RUN.
  - out keeps its old value until completion.
- Start while in RUN is ignored. Operand inputs are sampled only at accept.
- RUN, each edge:
  - pp = mcand * mplier[R-1:0], computed in RES_BIT width.
  - sum = acc + pp (mod 2^RES_BIT), acc<=sum.
  - mplier <<= 0 then >>= R; mcand <<= R; cnt++.
- Completion: when the shifted mplier==0 or cnt reaches N_BIT/R-1 on that edge.
  - out <= neg ? -sum : sum, taken mod 2^RES_BIT.
  - state->DONE, done->1.
- Latency: d edges after the accept edge, where d = max(1, ceil(bitlen(|a|)/R)). Maximum is N_BIT/R. A zero multiplier gives d=1 and out=0.
- Result width: the true product always fits in RES_BIT; no overflow.
- abort=1 in RUN: state->IDLE, busy->0, done stays 0, out unchanged.
- abort in IDLE or DONE: state->IDLE, done->0, out unchanged.
- abort has priority over start on the same edge.
- start on the same edge that DONE is entered cannot occur (busy=1 in RUN). A start while in DONE is accepted, and done drops on that edge.

Test Plan:
1. N_BIT=8, R=2, unsigned, a=200, b=100: start -> busy for 4 cycles; done=1 with out=16'h4E20 on the 4th edge after accept.
2. Both signed, a=8'h80, b=8'h80: -> out=16'h4000 after 4 cycles. Also a=8'h80 (signed), b=8'h7F (signed): -> out=16'hC080.
3. a_signed=1, b_signed=0, a=8'hFF, b=8'hFF: -> out=16'hFF01 after 1 cycle (early termination). Also a=0, b=8'hAB: -> out=0 after 1 cycle.
4. Unsigned a=3, b=5: -> out=15 after 1 cycle; done holds for 10 idle cycles. A second start a=7, b=7 then drops done on its accept edge and gives out=49.
5. Start a=200, b=100; after 2 cycles pulse start with a=1, b=1: -> the second start is ignored and out=16'h4E20. Then start again and assert abort 1 cycle later: -> busy=0, done=0, out=16'h4E20 retained.
6. rst_n low asynchronously (between edges) mid-RUN: -> busy, done and out go to 0 immediately. After release, a=255, b=255 unsigned -> out=16'hFE01 after 4 cycles.
